// File: rtl/arb_pkg.sv
// Package shared by the round-robin arbiter files.
//   NREQ        number of requesters
//   arb_state_t arbiter FSM states (IDLE, GRANT)
//   wrap_inc    2-bit modulo-4 increment used for the rotating pointer
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Pointer/owner increment; 3 wraps to 0 by natural 2-bit overflow.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority requester search (purely combinational).
// Ports:
//   req  [3:0] in   request lines
//   ptr  [1:0] in   index that currently has highest priority
//   pick [1:0] out  first set request found searching ptr, ptr+1, ptr+2, ptr+3
//   any        out  high when at least one request is set
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] pick,
  output logic             any
);

  // rot[k] is the request that sits k positions after ptr.
  logic [NREQ-1:0]  rot;
  logic [PTR_W-1:0] offset;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign rot[gi] = req[ptr + PTR_W'(gi)];
  end

  always_comb begin
    offset = '0;
    // Walk downwards so the smallest set offset is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = PTR_W'(k);
    end
  end

  assign pick = ptr + offset;
  assign any  = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold. Produces a registered
// one-hot grant (or all-zero) suitable for driving a 4-to-2 encoder.
// Ports:
//   clk        in       rising-edge clock
//   rst        in       asynchronous active-high reset
//   req  [3:0] in       request lines
//   done       in       owner release strobe, only looked at while granting
//   gnt  [3:0] out      registered one-hot grant, zero when idle
//   gnt_valid  out      registered, high exactly when gnt is non-zero
//   timeout    out      one-cycle pulse coincident with a forced release
// Optional feature: define ARB_TIMEOUT_EN to force release after HOLD_MAX
// cycles of continuous grant. Without it, timeout is constant 0 and a grant
// is held until done or the owner's request drops.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic            timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_param
    $error("rr_arbiter_4: illegal HOLD_MAX/CNT_W combination");
  end

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [PTR_W-1:0] pick;
  logic             any;
  logic             normal_rel;
  logic             force_rel;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  // done and a dropped owner request collapse into one release event, so
  // the pointer can only ever advance once per grant.
  assign normal_rel = done | ~req[owner_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign force_rel = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE) begin
      if (any) hold_cnt_d = '0;
    end else if (hold_cnt_q != '1) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = GRANT;
          owner_d     = pick;
          gnt_d       = NREQ'(1) << pick;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (normal_rel || force_rel) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = wrap_inc(owner_q);
          // A genuine release in the same cycle wins; no timeout pulse.
          timeout_d   = ~normal_rel;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       tmo;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  rr_arbiter_4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void add(input logic [3:0] r, input logic d,
                              input logic [3:0] g, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.tmo = t;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    exp_t e;
    req  = vecs[idx].req;
    done = vecs[idx].done;
    e.gnt = vecs[idx].gnt;
    e.tmo = vecs[idx].tmo;
    e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d_gnt", e.idx), gnt, e.gnt);
    check($sformatf("vec%0d_valid", e.idx), {3'b0, gnt_valid}, {3'b0, |e.gnt});
    check($sformatf("vec%0d_timeout", e.idx), {3'b0, timeout}, {3'b0, e.tmo});
    $display("vec %0d req=%b done=%b -> gnt=%b valid=%b timeout=%b",
             e.idx, vecs[idx].req, vecs[idx].done, gnt, gnt_valid, timeout);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #3;
    check("reset_gnt", gnt, 4'b0000);
    check("reset_valid", {3'b0, gnt_valid}, 4'b0000);
    check("reset_timeout", {3'b0, timeout}, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 4'b0000, 1'b0);
    // All requesting, done one cycle after each grant: full rotation.
    add(4'b1111, 1'b0, 4'b0001, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);
    add(4'b1111, 1'b0, 4'b0010, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);
    add(4'b1111, 1'b0, 4'b0100, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);
    add(4'b1111, 1'b0, 4'b1000, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);
    add(4'b1111, 1'b0, 4'b0001, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);   // ptr -> 1
    // Grant 1 so ptr becomes 2, then search wraps past 2,3 to 0.
    add(4'b0010, 1'b0, 4'b0010, 1'b0);
    add(4'b0010, 1'b1, 4'b0000, 1'b0);   // ptr -> 2
    add(4'b0011, 1'b0, 4'b0001, 1'b0);
    add(4'b0011, 1'b1, 4'b0000, 1'b0);   // ptr -> 1
    add(4'b0011, 1'b0, 4'b0010, 1'b0);
    add(4'b0011, 1'b1, 4'b0000, 1'b0);   // ptr -> 2
    // Owner 0 drops its request while req[3] waits.
    add(4'b0001, 1'b0, 4'b0001, 1'b0);
    add(4'b1000, 1'b0, 4'b0000, 1'b0);   // ptr -> 1
    add(4'b1000, 1'b0, 4'b1000, 1'b0);
    add(4'b1000, 1'b1, 4'b0000, 1'b0);   // ptr -> 0
    // Simultaneous done and request drop: ptr advances only once.
    add(4'b0010, 1'b0, 4'b0010, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);   // ptr -> 2
    add(4'b1111, 1'b0, 4'b0100, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);   // ptr -> 3
    // done is ignored while idle.
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 4'b0001, 1'b0);
    add(4'b0001, 1'b1, 4'b0000, 1'b0);   // ptr -> 1
    // No preemption by other requesters.
    add(4'b0100, 1'b0, 4'b0100, 1'b0);
    add(4'b1111, 1'b0, 4'b0100, 1'b0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0);   // ptr -> 3
    // Long hold on requester 1.
    add(4'b0010, 1'b0, 4'b0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) add(4'b0010, 1'b0, 4'b0010, 1'b0);
    add(4'b0010, 1'b0, 4'b0000, 1'b1);   // forced release, ptr -> 2
    add(4'b0010, 1'b0, 4'b0010, 1'b0);   // regrant after idle cycle
    for (int i = 0; i < 3; i++) add(4'b0010, 1'b0, 4'b0010, 1'b0);
    add(4'b0010, 1'b1, 4'b0000, 1'b0);   // done on the limit cycle wins
`else
    for (int i = 0; i < 8; i++) add(4'b0010, 1'b0, 4'b0010, 1'b0);
    add(4'b0010, 1'b1, 4'b0000, 1'b0);   // ptr -> 2
`endif

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // Asynchronous reset in the middle of a grant.
    req  = 4'b0100;
    done = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_gnt", gnt, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", gnt, 4'b0000);
    check("async_rst_valid", {3'b0, gnt_valid}, 4'b0000);
    $display("async reset mid-grant -> gnt=%b valid=%b", gnt, gnt_valid);
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b0101;
    @(posedge clk);
    #1;
    check("post_rst_gnt", gnt, 4'b0001);
    check("post_rst_valid", {3'b0, gnt_valid}, 4'b0001);
    $display("after reset req=0101 -> gnt=%b valid=%b", gnt, gnt_valid);

    check("scoreboard_empty", 4'(sb.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
